boxcar_channel_scheduler: RTL and testbench

Time-shares one moving-average (boxcar) engine between `NUM_CHANNELS` independent sample streams. Each cycle a round-robin arbiter accepts at most one sample. The sample passes through a shared read-modify-write accumulator that keeps per-channel history and running sums, and the block emits a channel-tagged average. It sits between multi-channel ADC/front-end sources and downstream per-channel consumers, and replaces one boxcar instance per channel.

---
 rtl/boxcar_channel_scheduler.sv | 142 ++++++++++++++
 tb/tb_boxcar_channel_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boxcar_channel_scheduler.sv
// Round-robin scheduler time-sharing one boxcar (moving-average) engine across channels.
// Define BOXCAR_SCHED_WARMUP_EN to suppress outputs until a channel's window is full.
module boxcar_channel_scheduler #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_SAMPLES  = 8,
  parameter int unsigned NUM_CHANNELS = 4,
  localparam int unsigned IW = $clog2(NUM_SAMPLES),
  localparam int unsigned CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  input  logic [NUM_CHANNELS-1:0]            i_ce,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_data,
  output logic [NUM_CHANNELS-1:0]            o_ready,
  output logic [DATA_WIDTH-1:0]              o_data,
  output logic [CW-1:0]                      o_chan,
  output logic                               o_ce,
  input  logic                               i_ready
);
  localparam int unsigned SW = DATA_WIDTH + IW;

  logic                    advance;
  logic [NUM_CHANNELS-1:0] grant;
  logic [CW-1:0]           grant_idx;
  logic [CW-1:0]           cand;
  logic                    found;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   sel_data;

  logic [CW-1:0]           rr_ptr_q;
  logic                    s1_valid_q;
  logic [CW-1:0]           s1_chan_q;
  logic [DATA_WIDTH-1:0]   s1_data_q;

  logic [DATA_WIDTH-1:0]   hist_q [NUM_CHANNELS][NUM_SAMPLES];
  logic signed [SW-1:0]    sum_q  [NUM_CHANNELS];
  logic [IW-1:0]           wptr_q [NUM_CHANNELS];

  logic [DATA_WIDTH-1:0]   old_sample;
  logic signed [SW-1:0]    sum_new;
  logic                    s2_fire;
  logic                    out_load;

  logic                    o_ce_q;
  logic [DATA_WIDTH-1:0]   o_data_q;
  logic [CW-1:0]           o_chan_q;

  // Arbiter: first requester at or above rr_ptr, with wrap.
  always_comb begin
    advance   = ~o_ce_q | i_ready;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      cand = CW'((32'(rr_ptr_q) + i) % NUM_CHANNELS);
      if (!found && i_ce[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
    o_ready  = (advance && i_reset_n) ? grant : '0;
    accept   = |(i_ce & o_ready);
    sel_data = i_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    s2_fire    = advance & s1_valid_q;
    old_sample = hist_q[s1_chan_q][wptr_q[s1_chan_q]];
    sum_new    = sum_q[s1_chan_q]
               + $signed({{IW{s1_data_q[DATA_WIDTH-1]}}, s1_data_q})
               - $signed({{IW{old_sample[DATA_WIDTH-1]}}, old_sample});
  end

`ifdef BOXCAR_SCHED_WARMUP_EN
  localparam logic [IW:0] FillFull = (IW+1)'(NUM_SAMPLES);

  logic [IW:0] fill_q [NUM_CHANNELS];
  logic [IW:0] fill_new;

  always_comb begin
    fill_new = fill_q[s1_chan_q];
    if (fill_new != FillFull) fill_new = fill_new + (IW+1)'(1);
    out_load = s2_fire && (fill_new == FillFull);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int c = 0; c < int'(NUM_CHANNELS); c++) fill_q[c] <= '0;
    end else if (s2_fire) begin
      fill_q[s1_chan_q] <= fill_new;
    end
  end
`else
  assign out_load = s2_fire;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_chan_q  <= '0;
      s1_data_q  <= '0;
      o_ce_q     <= 1'b0;
      o_data_q   <= '0;
      o_chan_q   <= '0;
      for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
        sum_q[c]  <= '0;
        wptr_q[c] <= '0;
        for (int s = 0; s < int'(NUM_SAMPLES); s++) hist_q[c][s] <= '0;
      end
    end else begin
      if (accept) begin
        rr_ptr_q <= (grant_idx == CW'(NUM_CHANNELS - 1)) ? '0 : grant_idx + CW'(1);
      end
      // Whole pipeline freezes together while the output is stalled.
      if (advance) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_chan_q <= grant_idx;
          s1_data_q <= sel_data;
        end
        o_ce_q <= out_load;
        if (out_load) begin
          o_data_q <= sum_new[SW-1:IW];
          o_chan_q <= s1_chan_q;
        end
      end
      if (s2_fire) begin
        sum_q[s1_chan_q]                    <= sum_new;
        hist_q[s1_chan_q][wptr_q[s1_chan_q]] <= s1_data_q;
        wptr_q[s1_chan_q]                   <= wptr_q[s1_chan_q] + IW'(1);
      end
    end
  end

  assign o_ce   = o_ce_q;
  assign o_data = o_data_q;
  assign o_chan = o_chan_q;

endmodule

// File: tb/tb_boxcar_channel_scheduler.sv
// Scoreboard bench for boxcar_channel_scheduler: a reference model predicts grants and
// channel-tagged averages in acceptance order.
module tb_boxcar_channel_scheduler;
  localparam int DW = 8;
  localparam int NS = 8;
  localparam int NC = 4;
  localparam int CW = 2;

  logic             i_clk = 1'b0;
  logic             i_reset_n = 1'b0;
  logic [NC-1:0]    i_ce = '0;
  logic [NC*DW-1:0] i_data = '0;
  logic             i_ready = 1'b1;
  logic [NC-1:0]    o_ready;
  logic [DW-1:0]    o_data;
  logic [CW-1:0]    o_chan;
  logic             o_ce;

  boxcar_channel_scheduler #(
    .DATA_WIDTH  (DW),
    .NUM_SAMPLES (NS),
    .NUM_CHANNELS(NC)
  ) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_ce     (i_ce),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_chan   (o_chan),
    .o_ce     (o_ce),
    .i_ready  (i_ready)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int q_chan[$];
  int q_data[$];
  int m_hist[NC][NS];
  int m_sum[NC];
  int m_wptr[NC];
  int m_fill[NC];
  int m_rr;
  int last_data[NC];
  logic          hold_v;
  logic [DW-1:0] hold_data;
  logic [CW-1:0] hold_chan;
  logic [NC-1:0] exp_rdy;
  int            idx;
  int            ec;
  int            ed;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor_div(input int a);
    if (a >= 0) return a / NS;
    return -((-a + NS - 1) / NS);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_sum[c]  = 0;
      m_wptr[c] = 0;
      m_fill[c] = 0;
      for (int s = 0; s < NS; s++) m_hist[c][s] = 0;
    end
    m_rr   = 0;
    hold_v = 1'b0;
    q_chan.delete();
    q_data.delete();
  endtask

  task automatic model_accept(input int c, input int v);
    int old;
    old = m_hist[c][m_wptr[c]];
    m_sum[c] += v - old;
    m_hist[c][m_wptr[c]] = v;
    m_wptr[c] = (m_wptr[c] + 1) % NS;
    if (m_fill[c] < NS) m_fill[c]++;
    m_rr = (c + 1) % NC;
`ifdef BOXCAR_SCHED_WARMUP_EN
    if (m_fill[c] == NS) begin
      q_chan.push_back(c);
      q_data.push_back(floor_div(m_sum[c]));
    end
`else
    q_chan.push_back(c);
    q_data.push_back(floor_div(m_sum[c]));
`endif
  endtask

  // Monitor samples mid-cycle, away from the rising edge.
  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      model_reset();
    end else begin
      if (hold_v) begin
        check_val("hold_data", int'($signed(o_data)), int'($signed(hold_data)));
        check_val("hold_chan", int'(o_chan), int'(hold_chan));
      end
      hold_v    = o_ce && !i_ready;
      hold_data = o_data;
      hold_chan = o_chan;
      if (o_ce && i_ready) begin
        if (q_chan.size() == 0) begin
          check_val("unexpected_out", 1, 0);
        end else begin
          ec = q_chan.pop_front();
          ed = q_data.pop_front();
          check_val("out_chan", int'(o_chan), ec);
          check_val("out_data", int'($signed(o_data)), ed);
          last_data[ec] = int'($signed(o_data));
        end
      end
      exp_rdy = '0;
      if (!o_ce || i_ready) begin
        for (int i = 0; i < NC; i++) begin
          idx = (m_rr + i) % NC;
          if (exp_rdy == '0 && i_ce[idx]) exp_rdy[idx] = 1'b1;
        end
      end
      check_val("grant", int'(o_ready), int'(exp_rdy));
      for (int c = 0; c < NC; c++) begin
        if (exp_rdy[c]) model_accept(c, int'($signed(i_data[c*DW +: DW])));
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input int ch, input int val, input int n);
    int got;
    int guard;
    got   = 0;
    guard = 0;
    i_ce[ch] = 1'b1;
    i_data[ch*DW +: DW] = val[DW-1:0];
    while (got < n && guard < 200) begin
      @(negedge i_clk);
      if (o_ready[ch]) got++;
      step();
      guard++;
    end
    i_ce[ch] = 1'b0;
    check_val("send_count", got, n);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q_chan.size() != 0 && g < 60) begin
      step();
      g++;
    end
    check_val("drain", q_chan.size(), 0);
    step();
    step();
  endtask

  task automatic pulse_reset();
    i_reset_n = 1'b0;
    step();
    i_reset_n = 1'b1;
  endtask

  initial begin
    for (int c = 0; c < NC; c++) last_data[c] = 999;
    // Requests during reset must never be granted.
    i_ce = '1;
    repeat (3) step();
    check_val("rst_o_ce", int'(o_ce), 0);
    check_val("rst_o_data", int'(o_data), 0);
    check_val("rst_o_chan", int'(o_chan), 0);
    check_val("rst_o_ready", int'(o_ready), 0);
    i_ce = '0;
    i_reset_n = 1'b1;
    step();

`ifdef BOXCAR_SCHED_WARMUP_EN
    send(0, 16, 7);
    i_ce[0] = 1'b1;
    @(negedge i_clk);
    check_val("lat_grant", int'(o_ready), 1);
    step();
    i_ce = '0;
    check_val("lat_k_o_ce", int'(o_ce), 0);
    step();
    check_val("lat_k1_o_ce", int'(o_ce), 1);
    check_val("lat_k1_data", int'($signed(o_data)), 16);
    check_val("lat_k1_chan", int'(o_chan), 0);
`else
    i_data[3*DW +: DW] = 8'd80;
    i_ce = 4'b1000;
    @(negedge i_clk);
    check_val("lat_grant", int'(o_ready), 8);
    step();
    i_ce = '0;
    check_val("lat_k_o_ce", int'(o_ce), 0);
    step();
    check_val("lat_k1_o_ce", int'(o_ce), 1);
    check_val("lat_k1_data", int'($signed(o_data)), 10);
    check_val("lat_k1_chan", int'(o_chan), 3);
`endif
    drain();

    // All channels requesting with constant data; then a 5-cycle output stall.
    pulse_reset();
    i_data = {8'd4, 8'd3, 8'd2, 8'd1};
    i_ce = 4'b1111;
    repeat (40) step();
    check_val("stall_pre_o_ce", int'(o_ce), 1);
    i_ready = 1'b0;
    repeat (5) begin
      step();
      check_val("stall_o_ready", int'(o_ready), 0);
    end
    i_ready = 1'b1;
    repeat (12) step();
    i_ce = '0;
    drain();
    for (int c = 0; c < NC; c++) check_val("steady_avg", last_data[c], c + 1);

    // Negative values and floor rounding on channel 2.
    pulse_reset();
    send(2, -3, 8);
    send(2, 0, 7);
    send(2, -1, 1);
    drain();
    check_val("floor_neg", last_data[2], -1);

    // Mid-stream reset must leave no residue.
    pulse_reset();
    send(1, 100, 5);
    i_reset_n = 1'b0;
    step();
    i_reset_n = 1'b1;
    check_val("rst_mid_o_ce", int'(o_ce), 0);
    last_data[1] = 999;
    send(1, 10, 8);
    drain();
    check_val("post_rst_avg", last_data[1], 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
